// File: rtl/i2c_reg_arbiter.sv
// Shares one single-port register RAM between the I2C slave register port and a host bus.
// Priority per cycle: pending I2C write, then I2C read-word refresh, then host request.
module i2c_reg_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i2c_write_en,
  input  logic [ADDR_WIDTH-1:0] i2c_reg_addr,
  input  logic [DATA_WIDTH-1:0] i2c_wdata,
  output logic [DATA_WIDTH-1:0] i2c_rdata,
  input  logic                  i2c_busy,
  input  logic                  i2c_done,
  output logic                  i2c_update,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {TAG_NONE, TAG_I2C, TAG_HOST} tag_t;

  logic                  wr_pend;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [DATA_WIDTH-1:0] pend_data;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  dirty;
  logic                  wr_seen;
  logic                  busy_q;
  tag_t                  issue_tag;
  tag_t                  ret_tag;

  logic do_wr, do_ref, do_host, wr_hit, busy_rise;

  // A host request is held off while a fresh I2C write is being captured so that
  // the write always goes to the RAM ahead of a simultaneous host access.
  always_comb begin
    do_wr     = wr_pend;
    do_ref    = !wr_pend && dirty;
    do_host   = !wr_pend && !dirty && host_req && !host_gnt && !i2c_write_en;
    wr_hit    = (do_wr && (pend_addr == fetch_addr)) ||
                (do_host && host_we && (host_addr == fetch_addr));
    busy_rise = i2c_busy && !busy_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_pend    <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      fetch_addr <= '0;
      dirty      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= i2c_busy;
      if (i2c_write_en) begin
        wr_pend   <= 1'b1;
        pend_addr <= i2c_reg_addr;
        pend_data <= i2c_wdata;
      end else if (do_wr) begin
        wr_pend <= 1'b0;
      end
      if (do_ref) begin
        fetch_addr <= i2c_reg_addr;
        dirty      <= 1'b0;
      end else if ((i2c_reg_addr != fetch_addr) || wr_hit) begin
        dirty <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_seen    <= 1'b0;
      i2c_update <= 1'b0;
    end else begin
      i2c_update <= 1'b0;
      if (i2c_done) begin
        i2c_update <= wr_seen || do_wr;
        wr_seen    <= 1'b0;
      end else if (busy_rise) begin
        wr_seen <= do_wr;
      end else if (do_wr) begin
        wr_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      host_gnt  <= 1'b0;
      issue_tag <= TAG_NONE;
    end else begin
      mem_en   <= do_wr || do_ref || do_host;
      mem_we   <= do_wr || (do_host && host_we);
      host_gnt <= do_host;
      if (do_wr) begin
        mem_addr  <= pend_addr;
        mem_wdata <= pend_data;
      end else if (do_ref) begin
        mem_addr <= i2c_reg_addr;
      end else if (do_host) begin
        mem_addr  <= host_addr;
        mem_wdata <= host_wdata;
      end
      if (do_ref)                   issue_tag <= TAG_I2C;
      else if (do_host && !host_we) issue_tag <= TAG_HOST;
      else                          issue_tag <= TAG_NONE;
    end
  end

  // The tag follows the RAM's one-cycle latency so returning data is steered in issue order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ret_tag     <= TAG_NONE;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      i2c_rdata   <= '0;
    end else begin
      ret_tag     <= issue_tag;
      host_rvalid <= (ret_tag == TAG_HOST);
      if (ret_tag == TAG_HOST) host_rdata <= mem_rdata;
      if (ret_tag == TAG_I2C)  i2c_rdata  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Directed bench for i2c_reg_arbiter with a behavioural 1-cycle-latency RAM.
module tb_i2c_reg_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i2c_write_en;
  logic [7:0]  i2c_reg_addr;
  logic [15:0] i2c_wdata;
  logic [15:0] i2c_rdata;
  logic        i2c_busy;
  logic        i2c_done;
  logic        i2c_update;
  logic        host_req;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_gnt;
  logic        host_rvalid;
  logic [15:0] host_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  logic [15:0] ram [256];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  i2c_reg_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .i2c_write_en(i2c_write_en), .i2c_reg_addr(i2c_reg_addr), .i2c_wdata(i2c_wdata),
    .i2c_rdata(i2c_rdata), .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_update(i2c_update),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (load_en) ram[load_addr] <= load_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
    chk({tag, "_gnt"}, {31'd0, host_gnt}, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, host_rvalid}, 32'd0);
    chk({tag, "_host_rdata"}, {16'd0, host_rdata}, 32'd0);
    chk({tag, "_i2c_rdata"}, {16'd0, i2c_rdata}, 32'd0);
    chk({tag, "_update"}, {31'd0, i2c_update}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    i2c_write_en = 1'b0; i2c_reg_addr = 8'h00; i2c_wdata = 16'h0000;
    i2c_busy = 1'b0; i2c_done = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 16'h0000;
    load_en = 1'b0; load_addr = 8'h00; load_data = 16'h0000;

    // Preload RAM while held in reset
    tick();
    load_en = 1'b1; load_addr = 8'h00; load_data = 16'hBEEF;
    tick();
    load_addr = 8'h12; load_data = 16'h1234;
    tick();
    load_en = 1'b0;
    tick();
    chk_reset_outputs("rst");

    // Reset refresh of address 0
    reset = 1'b0;
    tick();
    chk("rr_mem_en", {31'd0, mem_en}, 32'd1);
    chk("rr_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rr_mem_addr", {24'd0, mem_addr}, 32'h00);
    tick();
    tick();
    chk("rr_i2c_rdata", {16'd0, i2c_rdata}, 32'hBEEF);

    // Host read: gnt in cycle 1, rvalid in cycle 3, exactly one grant
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h12;
    tick();
    chk("hr_gnt1", {31'd0, host_gnt}, 32'd1);
    chk("hr_mem_addr", {24'd0, mem_addr}, 32'h12);
    tick();
    chk("hr_gnt2", {31'd0, host_gnt}, 32'd0);
    chk("hr_rvalid2", {31'd0, host_rvalid}, 32'd0);
    host_req = 1'b0;
    tick();
    chk("hr_rvalid3", {31'd0, host_rvalid}, 32'd1);
    chk("hr_rdata3", {16'd0, host_rdata}, 32'h1234);
    chk("hr_gnt3", {31'd0, host_gnt}, 32'd0);
    tick();
    chk("hr_rvalid4", {31'd0, host_rvalid}, 32'd0);
    chk("hr_rdata_hold", {16'd0, host_rdata}, 32'h1234);
    tick();

    // Collision: I2C write to 0x05 and host write to 0x06 in the same cycle
    i2c_write_en = 1'b1; i2c_reg_addr = 8'h05; i2c_wdata = 16'hA5A5;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h06; host_wdata = 16'h6666;
    tick();
    i2c_write_en = 1'b0;
    chk("col_c1_mem_en", {31'd0, mem_en}, 32'd0);
    chk("col_c1_gnt", {31'd0, host_gnt}, 32'd0);
    tick();
    chk("col_c2_we", {31'd0, mem_we}, 32'd1);
    chk("col_c2_addr", {24'd0, mem_addr}, 32'h05);
    chk("col_c2_wdata", {16'd0, mem_wdata}, 32'hA5A5);
    chk("col_c2_gnt", {31'd0, host_gnt}, 32'd0);
    tick();
    chk("col_c3_ref_en", {31'd0, mem_en}, 32'd1);
    chk("col_c3_ref_we", {31'd0, mem_we}, 32'd0);
    chk("col_c3_gnt", {31'd0, host_gnt}, 32'd0);
    tick();
    chk("col_c4_gnt", {31'd0, host_gnt}, 32'd1);
    chk("col_c4_we", {31'd0, mem_we}, 32'd1);
    chk("col_c4_addr", {24'd0, mem_addr}, 32'h06);
    tick();
    host_req = 1'b0;
    chk("col_c5_gnt", {31'd0, host_gnt}, 32'd0);
    chk("col_i2c_rdata", {16'd0, i2c_rdata}, 32'hA5A5);
    tick();
    chk("col_ram05", {16'd0, ram[5]}, 32'hA5A5);
    chk("col_ram06", {16'd0, ram[6]}, 32'h6666);

    // I2C write to the currently fetched address is followed by a refresh
    i2c_write_en = 1'b1; i2c_wdata = 16'h5A5A;
    tick();
    i2c_write_en = 1'b0;
    tick();
    chk("coh_c2_we", {31'd0, mem_we}, 32'd1);
    chk("coh_c2_wdata", {16'd0, mem_wdata}, 32'h5A5A);
    tick();
    chk("coh_c3_ref_en", {31'd0, mem_en}, 32'd1);
    chk("coh_c3_ref_we", {31'd0, mem_we}, 32'd0);
    chk("coh_c3_ref_addr", {24'd0, mem_addr}, 32'h05);
    tick();
    chk("coh_c4_old", {16'd0, i2c_rdata}, 32'hA5A5);
    tick();
    chk("coh_c5_new", {16'd0, i2c_rdata}, 32'h5A5A);
    tick();

    // Transaction with two writes, then done: one update pulse
    i2c_busy = 1'b1;
    tick();
    i2c_write_en = 1'b1; i2c_reg_addr = 8'h07; i2c_wdata = 16'h0707;
    tick();
    i2c_write_en = 1'b0;
    repeat (3) tick();
    i2c_write_en = 1'b1; i2c_reg_addr = 8'h08; i2c_wdata = 16'h0808;
    tick();
    i2c_write_en = 1'b0;
    repeat (4) tick();
    chk("upd_idle", {31'd0, i2c_update}, 32'd0);
    i2c_busy = 1'b0; i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    chk("upd_pulse", {31'd0, i2c_update}, 32'd1);
    tick();
    chk("upd_single", {31'd0, i2c_update}, 32'd0);
    chk("upd_ram07", {16'd0, ram[7]}, 32'h0707);
    chk("upd_ram08", {16'd0, ram[8]}, 32'h0808);

    // Mismatch transaction without writes: no pulse
    i2c_busy = 1'b1;
    repeat (2) tick();
    i2c_busy = 1'b0; i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    chk("nupd_c1", {31'd0, i2c_update}, 32'd0);
    tick();
    chk("nupd_c2", {31'd0, i2c_update}, 32'd0);

    // Host write to fetch_addr becomes visible on i2c_rdata
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h08; host_wdata = 16'hCAFE;
    tick();
    chk("hw_gnt", {31'd0, host_gnt}, 32'd1);
    tick();
    host_req = 1'b0;
    chk("hw_ref_en", {31'd0, mem_en}, 32'd1);
    chk("hw_ref_we", {31'd0, mem_we}, 32'd0);
    chk("hw_ref_addr", {24'd0, mem_addr}, 32'h08);
    tick();
    tick();
    chk("hw_i2c_rdata", {16'd0, i2c_rdata}, 32'hCAFE);
    chk("hw_no_rvalid", {31'd0, host_rvalid}, 32'd0);
    tick();

    // Reset in the cycle after host_gnt drops the in-flight read
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h12;
    tick();
    chk("rh_gnt", {31'd0, host_gnt}, 32'd1);
    tick();
    reset = 1'b1;
    host_req = 1'b0; i2c_reg_addr = 8'h00;
    #1;
    chk_reset_outputs("rh");
    tick();
    chk("rh_rvalid_a", {31'd0, host_rvalid}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("rh_ref_en", {31'd0, mem_en}, 32'd1);
    chk("rh_ref_we", {31'd0, mem_we}, 32'd0);
    chk("rh_ref_addr", {24'd0, mem_addr}, 32'h00);
    chk("rh_rvalid_b", {31'd0, host_rvalid}, 32'd0);
    tick();
    chk("rh_rvalid_c", {31'd0, host_rvalid}, 32'd0);
    tick();
    chk("rh_i2c_rdata", {16'd0, i2c_rdata}, 32'hBEEF);
    chk("rh_rvalid_d", {31'd0, host_rvalid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
